kf_au_arbiter: RTL

Two-requester arbiter that shares the single Kalman-filter arithmetic unit (AU) between the instruction sequencer path (requester 0) and a host/debug compute port (requester 1). It captures one request at a time, issues a one-cycle start to the AU with registered operands, waits for the AU done pulse, and returns the result to the granted requester. Fairness is round-robin. A watchdog aborts operations whose AU done pulse never arrives.

---
 rtl/kf_au_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/kf_au_arbiter.sv
// Round-robin arbiter sharing the Kalman-filter arithmetic unit between the
// sequencer (requester 0) and the host/debug port (requester 1), with a done watchdog.
module kf_au_arbiter #(
  parameter int W   = 24,
  parameter int TMO = 64,
  parameter int TW  = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] s0,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] s1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         tmo,
  output logic         err,
  output logic         busy,
  output logic         au_start,
  output logic [1:0]   au_op,
  output logic [W-1:0] au_r,
  output logic [W-1:0] au_s,
  input  logic         au_done,
  input  logic [W-1:0] au_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] cnt_q, cnt_n;
  logic          last_q, last_n;
  logic          owner_q, owner_n;
  logic          win;
  logic          ack0_n, ack1_n, done0_n, done1_n, start_n;
  logic          tmo_n, err_n, busy_n;
  logic [1:0]    op_n;
  logic [W-1:0]  r_n, s_n, result_n;

  // Every output is registered: the comb process only forms next-cycle values.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    last_n   = last_q;
    owner_n  = owner_q;
    win      = 1'b0;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
    start_n  = 1'b0;
    tmo_n    = 1'b0;
    err_n    = err;
    op_n     = au_op;
    r_n      = au_r;
    s_n      = au_s;
    result_n = result;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          win     = (req0 && req1) ? ~last_q : req1;
          owner_n = win;
          last_n  = win;
          op_n    = win ? op1 : op0;
          r_n     = win ? r1 : r0;
          s_n     = win ? s1 : s0;
          ack0_n  = ~win;
          ack1_n  = win;
          start_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A done arriving in the watchdog's last cycle still counts as a normal completion.
        if (au_done) begin
          result_n = au_result;
          done0_n  = ~owner_q;
          done1_n  = owner_q;
          state_n  = DONE;
        end else if (cnt_q == TW'(TMO - 1)) begin
          result_n = '0;
          tmo_n    = 1'b1;
          err_n    = 1'b1;
          done0_n  = ~owner_q;
          done1_n  = owner_q;
          state_n  = DONE;
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      au_start <= 1'b0;
      tmo      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      au_op    <= '0;
      au_r     <= '0;
      au_s     <= '0;
      result   <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      last_q   <= last_n;
      owner_q  <= owner_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      done0    <= done0_n;
      done1    <= done1_n;
      au_start <= start_n;
      tmo      <= tmo_n;
      err      <= err_n;
      busy     <= busy_n;
      au_op    <= op_n;
      au_r     <= r_n;
      au_s     <= s_n;
      result   <= result_n;
    end
  end

endmodule
